// File: rtl/debug_probe_sampler.sv
// Debug probe capture front-end: samples CHANNELS probe words periodically, on a
// masked-compare trigger or on a manual step, keeps the last DEPTH snapshots and shows one.
module debug_probe_sampler #(
    parameter int CHANNELS = 8,
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 4,
    parameter int DIV      = 5000000
) (
    input  logic                          clk_sys,
    input  logic                          reset_n,
    input  logic [CHANNELS*WIDTH-1:0]     probe_in,
    input  logic [1:0]                    mode,
    input  logic                          arm,
    input  logic                          step,
    input  logic [$clog2(CHANNELS)-1:0]   trig_ch,
    input  logic [WIDTH-1:0]              trig_mask,
    input  logic [WIDTH-1:0]              trig_value,
    input  logic [$clog2(DEPTH)-1:0]      view_sel,
    output logic [CHANNELS*WIDTH-1:0]     probe_out,
    output logic                          armed,
    output logic                          captured,
    output logic [$clog2(DEPTH):0]        snap_count,
    output logic                          tick
);

    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = CHANNELS * WIDTH;
    localparam int CNTW = $clog2(DIV);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] MODE_PERIODIC = 2'b00;
    localparam logic [1:0] MODE_SINGLE   = 2'b01;
    localparam logic [1:0] MODE_CONT     = 2'b10;

    logic [PW-1:0]    stage_q, stage_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [1:0]       state_q, state_d;
    logic             captured_q, captured_d;
    logic             match_prev_q, match_prev_d;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW:0]      count_q, count_d;
    logic             tick_q, tick_d;
    logic [PW-1:0]    out_q, out_d;
    logic [PW-1:0]    snap_mem_q [DEPTH];

    logic [WIDTH-1:0] stage_words [CHANNELS];
    logic             match;
    logic             per_hit;
    logic             trig_mode;
    logic             trig_cap;
    logic             cap_req;
    logic [AW-1:0]    rd_idx;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_words
            assign stage_words[gi] = stage_q[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Compare runs on the staged copy so a capture stores exactly the word that matched.
    assign match   = ((stage_words[trig_ch] ^ trig_value) & trig_mask) == '0;
    assign per_hit = (cnt_q == '0);

    always_comb begin
        stage_d      = probe_in;
        match_prev_d = match;
        cnt_d        = per_hit ? CNTW'(DIV - 1) : cnt_q - CNTW'(1);
    end

    always_comb begin
        state_d    = state_q;
        captured_d = captured_q;
        trig_cap   = 1'b0;
        trig_mode  = (mode == MODE_SINGLE) || (mode == MODE_CONT);
        if (!trig_mode) begin
            state_d = ST_IDLE;
        end else if (arm) begin
            // Re-arming restarts cleanly and suppresses any trigger in the same cycle.
            state_d    = ST_ARMED;
            captured_d = 1'b0;
        end else if (state_q == ST_ARMED) begin
            if (mode == MODE_SINGLE && match) begin
                trig_cap   = 1'b1;
                state_d    = ST_DONE;
                captured_d = 1'b1;
            end else if (mode == MODE_CONT && match && !match_prev_q) begin
                trig_cap   = 1'b1;
                captured_d = 1'b1;
            end
        end
        cap_req = step || ((mode == MODE_PERIODIC) && per_hit) || trig_cap;
    end

    always_comb begin
        wptr_d  = wptr_q;
        count_d = count_q;
        tick_d  = cap_req;
        if (cap_req) begin
            wptr_d = wptr_q + AW'(1);
            if (count_q != (AW+1)'(DEPTH)) begin
                count_d = count_q + (AW+1)'(1);
            end
        end
        rd_idx = wptr_q - AW'(1) - view_sel;
        out_d  = snap_mem_q[rd_idx];
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            stage_q      <= '0;
            cnt_q        <= CNTW'(DIV - 1);
            state_q      <= ST_IDLE;
            captured_q   <= 1'b0;
            match_prev_q <= 1'b0;
            wptr_q       <= '0;
            count_q      <= '0;
            tick_q       <= 1'b0;
            out_q        <= '0;
        end else begin
            stage_q      <= stage_d;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            captured_q   <= captured_d;
            match_prev_q <= match_prev_d;
            wptr_q       <= wptr_d;
            count_q      <= count_d;
            tick_q       <= tick_d;
            out_q        <= out_d;
        end
    end

    // Snapshot store; overflow simply overwrites the oldest entry.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                snap_mem_q[i] <= '0;
            end
        end else if (cap_req) begin
            snap_mem_q[wptr_q] <= stage_q;
        end
    end

    assign probe_out  = out_q;
    assign armed      = (state_q == ST_ARMED);
    assign captured   = captured_q;
    assign snap_count = count_q;
    assign tick       = tick_q;

endmodule

// File: tb/tb_debug_probe_sampler.sv
// Bench for debug_probe_sampler: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a snapshot-list reference model.
module tb_debug_probe_sampler;

    localparam int CHANNELS = 8;
    localparam int WIDTH    = 16;
    localparam int DEPTH    = 4;
    localparam int DIV      = 4;
    localparam int PW       = CHANNELS * WIDTH;

    logic              clk_sys = 1'b0;
    logic              reset_n;
    logic [PW-1:0]     probe_in;
    logic [1:0]        mode;
    logic              arm;
    logic              step;
    logic [2:0]        trig_ch;
    logic [WIDTH-1:0]  trig_mask;
    logic [WIDTH-1:0]  trig_value;
    logic [1:0]        view_sel;
    logic [PW-1:0]     probe_out;
    logic              armed;
    logic              captured;
    logic [2:0]        snap_count;
    logic              tick;

    int checks = 0;
    int errors = 0;
    int tick_seen = 0;

    // Reference model: newest-first snapshot list plus trigger bookkeeping.
    logic [PW-1:0] m_snaps [$];
    logic [PW-1:0] m_s;
    logic [PW-1:0] m_out;
    int            m_writes;
    int            m_n;
    bit            m_armed;
    bit            m_captured;
    bit            m_prev_match;
    bit            m_tick;

    logic [15:0]   pat [14];

    always #5 clk_sys = ~clk_sys;

    debug_probe_sampler #(
        .CHANNELS(CHANNELS),
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .DIV(DIV)
    ) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .probe_in(probe_in),
        .mode(mode),
        .arm(arm),
        .step(step),
        .trig_ch(trig_ch),
        .trig_mask(trig_mask),
        .trig_value(trig_value),
        .view_sel(view_sel),
        .probe_out(probe_out),
        .armed(armed),
        .captured(captured),
        .snap_count(snap_count),
        .tick(tick)
    );

    task automatic model_reset();
        m_snaps.delete();
        for (int i = 0; i < DEPTH; i++) m_snaps.push_back('0);
        m_s          = '0;
        m_out        = '0;
        m_writes     = 0;
        m_n          = 0;
        m_armed      = 1'b0;
        m_captured   = 1'b0;
        m_prev_match = 1'b0;
        m_tick       = 1'b0;
    endtask

    task automatic model_step();
        logic [WIDTH-1:0] w;
        bit match, per_hit, trig, cap;
        if (reset_n !== 1'b1) begin
            model_reset();
            return;
        end
        w       = m_s[int'(trig_ch)*WIDTH +: WIDTH];
        match   = ((w & trig_mask) == (trig_value & trig_mask));
        per_hit = (m_n % DIV) == (DIV - 1);
        trig    = 1'b0;
        if (mode == 2'b01 || mode == 2'b10) begin
            if (arm === 1'b1) begin
                m_armed    = 1'b1;
                m_captured = 1'b0;
            end else if (m_armed) begin
                if (mode == 2'b01 && match) begin
                    trig       = 1'b1;
                    m_armed    = 1'b0;
                    m_captured = 1'b1;
                end else if (mode == 2'b10 && match && !m_prev_match) begin
                    trig       = 1'b1;
                    m_captured = 1'b1;
                end
            end
        end else begin
            m_armed = 1'b0;
        end
        cap   = (step === 1'b1) || (mode == 2'b00 && per_hit) || trig;
        m_out = m_snaps[view_sel];
        if (cap) begin
            m_snaps.push_front(m_s);
            void'(m_snaps.pop_back());
            m_writes++;
        end
        m_tick       = cap;
        m_prev_match = match;
        m_s          = probe_in;
        m_n++;
    endtask

    task automatic check(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic compare_all();
        int sc;
        sc = (m_writes > DEPTH) ? DEPTH : m_writes;
        check("probe_out", probe_out, m_out);
        check("armed", PW'(armed), PW'(m_armed));
        check("captured", PW'(captured), PW'(m_captured));
        check("snap_count", PW'(snap_count), PW'(sc));
        check("tick", PW'(tick), PW'(m_tick));
    endtask

    task automatic cycle();
        @(posedge clk_sys);
        model_step();
        @(negedge clk_sys);
        compare_all();
        if (tick === 1'b1) tick_seen++;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        probe_in   = '0;
        mode       = 2'b00;
        arm        = 1'b0;
        step       = 1'b0;
        trig_ch    = '0;
        trig_mask  = '0;
        trig_value = '0;
        view_sel   = '0;
        model_reset();
        #1;
        compare_all();
        cycle();
        cycle();
        reset_n   = 1'b1;
        tick_seen = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        pat = '{16'h0, 16'hABCD, 16'hABCD, 16'hABCD, 16'h0, 16'hABCD, 16'h0,
                16'h0, 16'hABCD, 16'h0, 16'hABCD, 16'hABCD, 16'h0, 16'hABCD};
        @(negedge clk_sys);
        do_reset();
        check("reset_snap_count", PW'(snap_count), PW'(0));

        // Periodic capture of an incrementing ch0.
        for (int k = 0; k < 20; k++) begin
            probe_in[0 +: WIDTH] = 16'(k);
            cycle();
        end
        check("per_ticks", PW'(tick_seen), PW'(5));
        check("per_snap_count", PW'(snap_count), PW'(4));
        view_sel = 2'd0; cycle();
        check("per_view0", PW'(probe_out[0 +: WIDTH]), PW'(18));
        view_sel = 2'd1; cycle();
        check("per_view1", PW'(probe_out[0 +: WIDTH]), PW'(14));
        $display("periodic: ticks=%0d snap_count=%0d", tick_seen, snap_count);

        // Step on the same cycle as per_hit gives one capture.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            step = (k == 3);
            cycle();
        end
        step = 1'b0;
        check("coinc_snap_count", PW'(snap_count), PW'(2));
        $display("step+per_hit: snap_count=%0d", snap_count);

        // Single trigger on ch1 ramp.
        do_reset();
        mode = 2'b01; trig_ch = 3'd1; trig_mask = 16'hFF00; trig_value = 16'h1200;
        probe_in[WIDTH +: WIDTH] = 16'h11F0;
        arm = 1'b1; cycle(); arm = 1'b0;
        check("single_armed", PW'(armed), PW'(1));
        for (int i = 0; i < 80; i++) begin
            probe_in[0 +: WIDTH]     = 16'(i);
            probe_in[WIDTH +: WIDTH] = 16'h11F0 + 16'(i);
            cycle();
        end
        check("single_ticks", PW'(tick_seen), PW'(1));
        check("single_armed_after", PW'(armed), PW'(0));
        check("single_captured", PW'(captured), PW'(1));
        view_sel = 2'd0; cycle();
        check("single_data", PW'(probe_out[WIDTH +: WIDTH]), PW'(16'h1200));
        $display("single trigger: ticks=%0d captured=%0b", tick_seen, captured);

        // Continuous trigger on rising match of ch2.
        do_reset();
        mode = 2'b10; trig_ch = 3'd2; trig_mask = 16'hFFFF; trig_value = 16'hABCD;
        arm = 1'b1; cycle(); arm = 1'b0;
        for (int i = 0; i < 14; i++) begin
            probe_in[0 +: WIDTH]       = 16'(i);
            probe_in[2*WIDTH +: WIDTH] = pat[i];
            cycle();
        end
        probe_in[2*WIDTH +: WIDTH] = 16'h0;
        repeat (3) cycle();
        check("cont_ticks", PW'(tick_seen), PW'(5));
        check("cont_armed", PW'(armed), PW'(1));
        view_sel = 2'd3; cycle();
        check("cont_view3_ch0", PW'(probe_out[0 +: WIDTH]), PW'(5));
        check("cont_view3_ch2", PW'(probe_out[2*WIDTH +: WIDTH]), PW'(16'hABCD));
        $display("continuous trigger: ticks=%0d", tick_seen);

        // Hold mode with manual steps.
        do_reset();
        mode = 2'b11;
        for (int v = 1; v <= 3; v++) begin
            probe_in[0 +: WIDTH] = 16'(v);
            cycle();
            step = 1'b1; cycle(); step = 1'b0;
        end
        repeat (6) cycle();
        check("hold_ticks", PW'(tick_seen), PW'(3));
        for (int v = 0; v < 3; v++) begin
            view_sel = 2'(v); cycle();
            check("hold_view", PW'(probe_out[0 +: WIDTH]), PW'(3 - v));
        end
        $display("hold steps: ticks=%0d", tick_seen);

        // Reset asserted while a capture is pending.
        do_reset();
        mode = 2'b01; trig_ch = 3'd0; trig_mask = 16'hFFFF; trig_value = 16'h0055;
        arm = 1'b1; cycle(); arm = 1'b0;
        probe_in[0 +: WIDTH] = 16'h0055;
        cycle();
        reset_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("rst_probe_out", probe_out, PW'(0));
        check("rst_armed", PW'(armed), PW'(0));
        cycle(); cycle();
        reset_n = 1'b1;
        cycle(); cycle();
        check("rst_snap_count", PW'(snap_count), PW'(0));
        mode = 2'b00; arm = 1'b1; cycle(); arm = 1'b0;
        check("arm_mode00", PW'(armed), PW'(0));
        $display("reset mid-capture: snap_count=%0d", snap_count);

        // Leaving single-trigger mode while armed.
        do_reset();
        mode = 2'b01; arm = 1'b1; cycle(); arm = 1'b0;
        check("switch_armed", PW'(armed), PW'(1));
        mode = 2'b00; cycle();
        check("switch_disarmed", PW'(armed), PW'(0));
        repeat (12) cycle();
        check("switch_ticks", PW'(tick_seen), PW'(3));
        $display("mode switch: ticks=%0d", tick_seen);

        // Randomized run.
        do_reset();
        trig_mask = 16'hFFFF;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            arm  = ($urandom_range(0, 14) == 0);
            step = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 29) == 0) begin
                trig_ch    = 3'($urandom_range(0, 7));
                trig_value = 16'($urandom_range(0, 3));
                case ($urandom_range(0, 4))
                    0:       trig_mask = 16'hFFFF;
                    1:       trig_mask = 16'h0003;
                    2:       trig_mask = 16'h0001;
                    3:       trig_mask = 16'h0000;
                    default: trig_mask = 16'($urandom);
                endcase
            end
            for (int k = 0; k < CHANNELS; k++) begin
                probe_in[k*WIDTH +: WIDTH] = ($urandom_range(0, 4) == 0) ?
                    16'($urandom) : 16'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 3) == 0) view_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 699) == 0) begin
                reset_n = 1'b0;
                model_reset();
                #1;
                compare_all();
                cycle();
                cycle();
                reset_n = 1'b1;
            end
            cycle();
        end
        $display("random run: %0d ticks observed", tick_seen);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
